// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Main control FSM for a multicycle MIPS datapath. It steps each instruction
// through fetch, decode, execute, memory and writeback. It drives the datapath
// mux selects and write enables, and produces the ALU operation code.
//
// Handshake: mem_ready is the single completion strobe for every memory
// access. Instruction fetch uses it in FETCH, loads in MEMRD and stores in
// MEMWR. The FSM holds its state, and keeps the access request on
// iord/memWrite, until mem_ready is sampled high on a rising clock edge. The
// access completes in that cycle. There is no separate valid signal because
// the request is implied by the state.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   opcode        instr[31:26] from the instruction register
//   funct         instr[5:0] from the instruction register
//   zero          ALU zero flag; meaningful only while aluControl = SUB
//   mem_ready     memory access completes this cycle
//   aluControl    AND=0000 OR=0001 ADD=0010 SUB=0110 SLT=0111
//   aluSrcA       0=PC, 1=regA
//   aluSrcB       00=regB, 01=4, 10=signext imm, 11=signext imm<<2
//   pcSrc         00=ALU result, 01=ALUOut, 10=jump target
//   pcEn          PC load
//   irWrite       instruction register load
//   iord          memory address mux: 0=PC, 1=ALUOut
//   memWrite      memory write strobe
//   regWrite      register file write
//   regDst        0=rt, 1=rd
//   memToReg      0=ALUOut, 1=MDR
//   illegal_instr one-cycle pulse on unsupported opcode or funct
//   state_dbg     current state encoding
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int OPW = 6,
    parameter int ACW = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] funct,
    input  logic           zero,
    input  logic           mem_ready,
    output logic [ACW-1:0] aluControl,
    output logic           aluSrcA,
    output logic [1:0]     aluSrcB,
    output logic [1:0]     pcSrc,
    output logic           pcEn,
    output logic           irWrite,
    output logic           iord,
    output logic           memWrite,
    output logic           regWrite,
    output logic           regDst,
    output logic           memToReg,
    output logic           illegal_instr,
    output logic [3:0]     state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    localparam logic [OPW-1:0] FN_ADD   = OPW'(6'b100000);
    localparam logic [OPW-1:0] FN_SUB   = OPW'(6'b100010);
    localparam logic [OPW-1:0] FN_AND   = OPW'(6'b100100);
    localparam logic [OPW-1:0] FN_OR    = OPW'(6'b100101);
    localparam logic [OPW-1:0] FN_SLT   = OPW'(6'b101010);

    localparam logic [ACW-1:0] ALU_AND  = ACW'(4'b0000);
    localparam logic [ACW-1:0] ALU_OR   = ACW'(4'b0001);
    localparam logic [ACW-1:0] ALU_ADD  = ACW'(4'b0010);
    localparam logic [ACW-1:0] ALU_SUB  = ACW'(4'b0110);
    localparam logic [ACW-1:0] ALU_SLT  = ACW'(4'b0111);

    state_t state, state_next;

    // R-type funct decode, shared by the next-state and output logic
    logic           funct_ok;
    logic [ACW-1:0] funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            // MEMADR is reached only for lw or sw, so it only needs to check for sw.
            S_MEMADR:  state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_next = funct_ok ? S_ALUWB : S_FETCH;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH; // writeback/branch/jump and codes 12-15
        endcase
    end

    // Output decode: Moore except pcEn, irWrite and illegal_instr
    always_comb begin
        aluControl    = '0;
        aluSrcA       = 1'b0;
        aluSrcB       = 2'b00;
        pcSrc         = 2'b00;
        pcEn          = 1'b0;
        irWrite       = 1'b0;
        iord          = 1'b0;
        memWrite      = 1'b0;
        regWrite      = 1'b0;
        regDst        = 1'b0;
        memToReg      = 1'b0;
        illegal_instr = 1'b0;
        case (state)
            S_FETCH: begin
                aluControl = ALU_ADD;
                aluSrcB    = 2'b01;
                pcEn       = mem_ready;
                irWrite    = mem_ready;
            end
            S_DECODE: begin
                aluControl = ALU_ADD;
                aluSrcB    = 2'b11;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_instr = 1'b0;
                    default:                                       illegal_instr = 1'b1;
                endcase
            end
            S_MEMADR: begin
                aluControl = ALU_ADD;
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memWrite = 1'b1;
            end
            S_EXECUTE: begin
                aluControl    = funct_alu;
                aluSrcA       = 1'b1;
                illegal_instr = ~funct_ok;
            end
            S_ALUWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
            end
            S_BRANCH: begin
                aluControl = ALU_SUB;
                aluSrcA    = 1'b1;
                pcSrc      = 2'b01;
                pcEn       = zero;
            end
            S_ADDIEX: begin
                aluControl = ALU_ADD;
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
            end
            S_ADDIWB:  regWrite = 1'b1;
            S_JUMP: begin
                pcSrc = 2'b10;
                pcEn  = 1'b1;
            end
            default: ;
        endcase
        // While reset is held, every strobe and select is forced quiet at once.
        // FETCH decodes would otherwise follow mem_ready.
        if (!reset_n) begin
            aluControl    = ALU_ADD;
            aluSrcA       = 1'b0;
            aluSrcB       = 2'b00;
            pcSrc         = 2'b00;
            pcEn          = 1'b0;
            irWrite       = 1'b0;
            iord          = 1'b0;
            memWrite      = 1'b0;
            regWrite      = 1'b0;
            regDst        = 1'b0;
            memToReg      = 1'b0;
            illegal_instr = 1'b0;
        end
    end

    assign state_dbg = state;

endmodule
